// File: rtl/fetch_unit_pkg.sv
// Shared types for the LC-3b fetch stage: machine word, fetch-buffer entry,
// fetch state encoding and PC helpers.
package fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } lc3b_fetch_entry;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    DISCARD = ST_DISCARD
  } lc3b_fetch_state;

  localparam lc3b_word PC_STEP = 16'd2;

  // Instructions are word aligned; the byte-select bit of a target is dropped.
  function automatic lc3b_word align_pc(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between the cache response and the
// instruction queue. Clear dominates push and pop.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  lc3b_fetch_entry push_data,
  input  logic            pop,
  output lc3b_fetch_entry head,
  output logic [1:0]      count
);

  lc3b_fetch_entry entries [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = entries[rd_ptr];

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      // NOTE: the storage is reset too because the idle head drives iq_pc and
      // iq_instr, which must read zero out of reset.
      entries[0] <= '0;
      entries[1] <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LC-3b fetch stage: sequential PC generation, single-word cache reads,
// 2-entry fetch buffer feeding the instruction queue, redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        iq_full,
  output logic        iq_load,
  output logic [15:0] iq_pc,
  output logic [15:0] iq_instr
);

  logic [1:0]      state;
  logic [1:0]      state_next;
  lc3b_word        pc;
  lc3b_word        pc_next;
  lc3b_word        req_addr;
  lc3b_word        req_addr_next;
  logic            buf_push;
  logic            buf_clear;
  lc3b_fetch_entry push_data;
  lc3b_fetch_entry head;
  logic [1:0]      count;
  logic [1:0]      occ_next;
  logic            space_ok;
  logic            back_to_back;

  // Data is only ever presented from the buffer, never bypassed from mem_rdata.
  assign iq_load      = (count != 2'd0) && !iq_full && !redirect;
  assign occ_next     = count - {1'b0, iq_load};
  assign space_ok     = occ_next <= 2'd1;
  assign back_to_back = occ_next == 2'd0;
  assign push_data    = '{pc: req_addr, instr: mem_rdata};

  assign mem_read    = (state == ST_REQ) || (state == ST_DISCARD);
  assign mem_address = req_addr;
  assign iq_pc       = head.pc;
  assign iq_instr    = head.instr;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    buf_push      = 1'b0;
    buf_clear     = 1'b0;
    if (redirect) begin
      buf_clear = 1'b1;
      pc_next   = align_pc(redirect_pc);
      case (state)
        ST_REQ:     state_next = mem_resp ? ST_IDLE : ST_DISCARD;
        ST_DISCARD: state_next = ST_DISCARD;
        default:    state_next = ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (space_ok) begin
            req_addr_next = pc;
            state_next    = ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_resp) begin
            buf_push = 1'b1;
            pc_next  = pc + PC_STEP;
            // Keep streaming only if the buffer will still hold at most one.
            if (back_to_back) begin
              req_addr_next = pc + PC_STEP;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (mem_resp) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .clear     (buf_clear),
    .push      (buf_push),
    .push_data (push_data),
    .pop       (iq_load),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cache responder plus a program-order
// stream model, directed scenarios, a random phase, and a wrap-around instance.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        iq_full;
  logic        iq_load;
  logic [15:0] iq_pc;
  logic [15:0] iq_instr;

  logic        w_reset;
  logic        w_mem_read;
  logic [15:0] w_mem_address;
  logic        w_mem_resp;
  logic [15:0] w_mem_rdata;
  logic        w_iq_load;
  logic [15:0] w_iq_pc;
  logic [15:0] w_iq_instr;

  int tests = 0;
  int fails = 0;

  // Stimulus controls used by the directed steps.
  int          lat       = 1;
  bit          full_ctl  = 1'b0;
  bit          redir_ctl = 1'b0;
  logic [15:0] redir_pc_ctl = 16'h0000;
  bit          rst_ctl   = 1'b1;
  bit          rand_mode = 1'b0;

  // Reference model: expected program-order stream and cache bookkeeping.
  logic [15:0] exp_q [$];
  logic [15:0] fetch_ptr = 16'h0000;
  int          epoch     = 0;
  int          req_epoch = 0;
  int          wait_cnt  = 0;
  bit          prev_read = 1'b0;
  bit          prev_resp = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  logic        obs_read;
  logic [15:0] obs_addr;
  logic        obs_resp;
  logic        obs_load;
  logic [15:0] obs_pc;
  logic [15:0] obs_instr;

  fetch_unit dut (
    .clk         (clk),
    .reset       (rst),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iq_full     (iq_full),
    .iq_load     (iq_load),
    .iq_pc       (iq_pc),
    .iq_instr    (iq_instr)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk         (clk),
    .reset       (w_reset),
    .mem_read    (w_mem_read),
    .mem_address (w_mem_address),
    .mem_resp    (w_mem_resp),
    .mem_rdata   (w_mem_rdata),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .iq_full     (1'b0),
    .iq_load     (w_iq_load),
    .iq_pc       (w_iq_pc),
    .iq_instr    (w_iq_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return {addr[7:0] ^ 8'h3C, addr[15:8] ^ 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // One clock: drive inputs at the falling edge, check, then advance.
  task automatic cycle();
    logic        start;
    logic        fresh;
    logic [31:0] r;
    rst       = rst_ctl;
    start     = !rst_ctl && mem_read && (!prev_read || prev_resp);
    fresh     = start || (req_epoch == epoch);
    mem_rdata = mem_word(mem_address);
    mem_resp  = !rst_ctl && mem_read && (wait_cnt + 1 >= lat);
    if (rand_mode) begin
      r           = $urandom;
      redirect    = (r[3:0] < 4'd2);
      iq_full     = (r[7:4] < 4'd5);
      redirect_pc = r[31:16];
      if (mem_resp && !fresh) redirect = 1'b0;
    end else begin
      redirect    = redir_ctl && !rst_ctl;
      iq_full     = full_ctl;
      redirect_pc = redir_pc_ctl;
    end
    #1;
    obs_read  = mem_read;
    obs_addr  = mem_address;
    obs_resp  = mem_resp;
    obs_load  = iq_load;
    obs_pc    = iq_pc;
    obs_instr = iq_instr;
    if (rst_ctl) begin
      exp_q.delete();
      fetch_ptr = 16'h0000;
      wait_cnt  = 0;
      prev_read = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (start) begin
        check("req_addr", mem_address, fetch_ptr);
        check("occ_at_req", exp_q.size() <= 1, 1);
        req_epoch = epoch;
      end else if (mem_read && prev_read) begin
        check("addr_stable", mem_address, prev_addr);
      end
      check("iq_load", iq_load, (exp_q.size() > 0) && !iq_full && !redirect);
      if (iq_load && exp_q.size() > 0) begin
        check("iq_pc", iq_pc, exp_q[0]);
        check("iq_instr", iq_instr, mem_word(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (redirect) begin
        exp_q.delete();
        fetch_ptr = redirect_pc & 16'hFFFE;
        epoch++;
      end else if (mem_resp && req_epoch == epoch) begin
        exp_q.push_back(mem_address);
        fetch_ptr = mem_address + 16'd2;
        check("occupancy", exp_q.size() <= 2, 1);
      end
      if (mem_resp) begin
        wait_cnt = 0;
        if (rand_mode) lat = $urandom_range(1, 3);
      end else if (mem_read) begin
        wait_cnt++;
      end
      prev_read = mem_read;
      prev_resp = mem_resp;
      prev_addr = mem_address;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ctl = 1'b1;
    cycle();
    cycle();
    rst_ctl = 1'b0;
  endtask

  task automatic expect_first_load(input string tag, input logic [15:0] pc_exp);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle();
      if (obs_load) begin
        got = 1'b1;
        check(tag, obs_pc, pc_exp);
      end
    end
    check({tag, "_seen"}, got, 1);
  endtask

  task automatic w_tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; iq_full = 1'b0;
    w_reset = 1'b1; w_mem_resp = 1'b0; w_mem_rdata = '0;
    @(negedge clk);

    // Reset state, then back-to-back streaming with a 1-cycle cache.
    do_reset();
    lat = 1; full_ctl = 1'b0;
    cycle();
    check("rst_mem_read", obs_read, 0);
    check("rst_mem_address", obs_addr, 16'h0000);
    check("rst_iq_load", obs_load, 0);
    check("rst_iq_pc", obs_pc, 16'h0000);
    check("rst_iq_instr", obs_instr, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stream_read", obs_read, 1);
      check("stream_addr", obs_addr, 16'(2 * i));
      check("stream_load", obs_load, i > 0);
      if (i > 0) check("stream_pc", obs_pc, 16'(2 * (i - 1)));
    end

    // Queue full: exactly two entries buffered, then drain and resume.
    do_reset();
    full_ctl = 1'b1;
    cycle();
    cycle(); check("full_addr0", obs_addr, 16'h0000);
    cycle(); check("full_addr2", obs_addr, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("full_no_read", obs_read, 0);
    end
    full_ctl = 1'b0;
    cycle(); check("drain_pc0", obs_pc, 16'h0000); check("drain_load0", obs_load, 1);
    cycle(); check("drain_pc2", obs_pc, 16'h0002); check("resume_addr", obs_addr, 16'h0004);
    check("resume_read", obs_read, 1);

    // Redirect while waiting on 0006 with 3-cycle latency.
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    lat = 3; redir_ctl = 1'b1; redir_pc_ctl = 16'h3000;
    cycle();
    check("redir_addr6", obs_addr, 16'h0006);
    check("redir_no_load", obs_load, 0);
    redir_ctl = 1'b0;
    cycle(); check("discard_hold", obs_read, 1);
    cycle(); check("discard_resp", obs_resp, 1); check("discard_addr", obs_addr, 16'h0006);
    cycle(); check("discard_idle", obs_read, 0);
    cycle(); check("redir_target", obs_addr, 16'h3000);
    expect_first_load("redir_first_pc", 16'h3000);

    // Redirect in the same cycle as a response with an entry buffered.
    do_reset();
    lat = 1; full_ctl = 1'b1;
    cycle();
    cycle();
    full_ctl = 1'b0; redir_ctl = 1'b1; redir_pc_ctl = 16'h2001;
    cycle();
    check("same_resp", obs_resp, 1);
    check("same_no_load", obs_load, 0);
    redir_ctl = 1'b0;
    cycle(); check("same_empty", obs_load, 0); check("same_idle", obs_read, 0);
    cycle(); check("same_target", obs_addr, 16'h2000);
    expect_first_load("same_first_pc", 16'h2000);

    // Two redirects during a single discard window.
    do_reset();
    lat = 4;
    cycle();
    cycle();
    redir_ctl = 1'b1; redir_pc_ctl = 16'h4000;
    cycle();
    redir_pc_ctl = 16'h5000;
    cycle(); check("double_hold_addr", obs_addr, 16'h0000);
    redir_ctl = 1'b0;
    cycle(); check("double_resp", obs_resp, 1);
    cycle();
    cycle(); check("double_target", obs_addr, 16'h5000);
    expect_first_load("double_first_pc", 16'h5000);

    // Random traffic against the stream model.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) cycle();
    rand_mode = 1'b0; redir_ctl = 1'b0; full_ctl = 1'b0; lat = 1;
    begin
      int loads = 0;
      for (int i = 0; i < 30; i++) begin
        cycle();
        if (obs_load) loads++;
      end
      check("drain_progress", loads >= 5, 1);
    end

    // RESET_PC = FFFE: wrap-around and reset in the middle of a request.
    w_reset = 1'b1;
    w_tick();
    w_tick();
    w_reset = 1'b0;
    check("wrap_rst_read", w_mem_read, 0);
    check("wrap_rst_addr", w_mem_address, 16'hFFFE);
    w_tick();
    check("wrap_req_read", w_mem_read, 1);
    check("wrap_req_addr", w_mem_address, 16'hFFFE);
    w_mem_resp = 1'b1; w_mem_rdata = mem_word(16'hFFFE);
    w_tick();
    w_mem_resp = 1'b0;
    check("wrap_next_addr", w_mem_address, 16'h0000);
    check("wrap_load", w_iq_load, 1);
    check("wrap_pc", w_iq_pc, 16'hFFFE);
    check("wrap_instr", w_iq_instr, mem_word(16'hFFFE));
    w_tick();
    check("wrap_wait_read", w_mem_read, 1);
    w_reset = 1'b1;
    w_tick();
    w_reset = 1'b0;
    check("midreq_read", w_mem_read, 0);
    check("midreq_load", w_iq_load, 0);
    check("midreq_addr", w_mem_address, 16'hFFFE);
    w_tick();
    check("midreq_restart", w_mem_address, 16'hFFFE);
    check("midreq_restart_read", w_mem_read, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
